// File: rtl/adapter_pkg.sv
// Shared definitions for the adapter stream arbiter: FSM encoding, default pad
// value and a constant-evaluable ceil(log2) helper.
package adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_PAD_VALUE = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adapter_stream_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_SRC.
module rr_pick
    import adapter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned SRC_W = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic               found,
    output logic [SRC_W-1:0]   idx
);

    int unsigned pos;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
            pos = 32'(ptr) + 32'(k);
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            if (req[SRC_W'(pos)]) begin
                found = 1'b1;
                idx   = SRC_W'(pos);
            end
        end
    end

endmodule

// File: rtl/adapter_stream_arbiter.sv
// Packet-granular round-robin arbiter in front of the n->2n packer; pads
// odd-length packets with one filler beat so the packer always sees pairs.
module adapter_stream_arbiter
    import adapter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned WIDTH_DIN = 8,
    parameter logic [WIDTH_DIN-1:0] PAD_VALUE = WIDTH_DIN'(DEFAULT_PAD_VALUE),
    localparam int unsigned SRC_W = clog2(NUM_SRC)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_vld,
    input  logic [NUM_SRC-1:0]           src_last,
    input  logic [NUM_SRC*WIDTH_DIN-1:0] src_data,
    output logic [NUM_SRC-1:0]           src_rdy,
    output logic                         dout_vld,
    output logic                         dout_last,
    output logic [WIDTH_DIN-1:0]         dout,
    output logic [SRC_W-1:0]             dout_src,
    output logic                         dout_pad
);

    state_t               state;
    logic [SRC_W-1:0]     gnt;
    logic [SRC_W-1:0]     rr_ptr;
    logic                 par;

    logic                 pick_found;
    logic [SRC_W-1:0]     pick_idx;
    logic                 gnt_vld;
    logic                 gnt_last;
    logic [WIDTH_DIN-1:0] gnt_data;
    logic [SRC_W-1:0]     gnt_next;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .req   (src_vld),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Mux the granted source's beat.
    always_comb begin
        gnt_vld  = src_vld[gnt];
        gnt_last = src_last[gnt];
        gnt_data = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (gnt == SRC_W'(i)) begin
                gnt_data = src_data[i*WIDTH_DIN +: WIDTH_DIN];
            end
        end
    end

    assign gnt_next = (gnt == SRC_W'(NUM_SRC - 1)) ? '0 : gnt + SRC_W'(1);

    // Ready depends only on state and grant, never on src_vld.
    always_comb begin
        src_rdy = '0;
        if (state == ST_GRANT) begin
            src_rdy[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            par       <= 1'b0;
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
            dout      <= '0;
            dout_src  <= '0;
            dout_pad  <= 1'b0;
        end else begin
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
            dout_pad  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        gnt   <= pick_idx;
                        par   <= 1'b0;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (gnt_vld) begin
                        dout     <= gnt_data;
                        dout_vld <= 1'b1;
                        dout_src <= gnt;
                        par      <= ~par;
                        // par=1 here means this beat makes the packet even.
                        if (gnt_last && par) begin
                            dout_last <= 1'b1;
                            rr_ptr    <= gnt_next;
                            state     <= ST_IDLE;
                        end else if (gnt_last) begin
                            state <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    dout      <= PAD_VALUE;
                    dout_vld  <= 1'b1;
                    dout_last <= 1'b1;
                    dout_pad  <= 1'b1;
                    dout_src  <= gnt;
                    rr_ptr    <= gnt_next;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
